clock_core_param: RTL
=====================

Name: clock_core_param

Overview:
Parametrised BCD timekeeping core for the seven-segment digital clock. Replaces the fixed 50 MHz / 1 Hz, 24-hour-only time chain with:
- a generic tick divider;
- a separate auto-repeat adjust rate;
- run-time 12/24-hour output mode;
- an HH:MM alarm with a bounded ring duration.

Outputs are packed BCD and feed the existing display multiplexer directly.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 1, timekeeping tick rate; CLK_HZ/TICK_HZ must be an integer >= 2
ADJ_HZ, 4, auto-repeat rate while an adjust key is held; CLK_HZ/ADJ_HZ must be an integer >= 2
ALARM_SEC, 30, alarm ring length in ticks (1..255)

Ports:
CLK_50M  in  1  system clock, rising edge
nCR  in  1  reset, asynchronous, active-low
EN  in  1  1 = time runs; 0 = seconds frozen, normal carries suppressed
Adj_Min  in  1  level; minute steps at ADJ_HZ while high
Adj_Hour  in  1  level; hour steps at ADJ_HZ while high
Mode12  in  1  1 = 12-hour output format, 0 = 24-hour
Alm_On  in  1  alarm enable
Alm_Hour  in  8  alarm hour, BCD 00..23, sampled continuously
Alm_Min  in  8  alarm minute, BCD 00..59
Hour  out  8  BCD hour (00..23, or 01..12 in 12-hour mode)
Minute  out  8  BCD minute 00..59
Second  out  8  BCD second 00..59
PM  out  1  1 when internal hour >= 12 (valid in both modes)
Sec  out  1  square wave at TICK_HZ, 50% duty
Tick  out  1  one-cycle strobe per tick
Alarm  out  1  alarm ringing

Behaviour:
- Clock and reset: one clock, CLK_50M; reset nCR is asynchronous, active-low. All state clears on nCR=0.
- Reset values:
  - time 00:00:00;
  - Hour = 8'h00 in 24-hour mode, 8'h12 in 12-hour mode (combinational mapping);
  - PM = 0, Sec = 0, Tick = 0, Alarm = 0;
  - divider counters = 0.
- Tick divider: counter counts 0..CLK_HZ/TICK_HZ-1.
  - Tick = 1 for the single cycle in which the counter is at its maximum; counter then wraps to 0.
  - Sec is high during the second half of the count.
  - The divider runs regardless of EN.
- Adjust divider: same structure at ADJ_HZ, producing an internal strobe adj_stb.
  - The adjust counter is held at 0 while Adj_Min=Adj_Hour=0, so the first step comes one full ADJ period after a key is pressed.
- Time registers: internal 24-hour BCD digits. All updates happen on the Tick cycle or the adj_stb cycle, which take effect on the next edge.
  - Seconds: on Tick with EN=1, increment 00..59, then wrap to 00 with carry.
  - Minutes:
    - If Adj_Min=1: increment on adj_stb, wrap 59->00, no carry into hours; the seconds carry is ignored.
    - Else: increment on the seconds carry; wrap 59->00 with carry into hours.
  - Hours:
    - If Adj_Hour=1: increment on adj_stb, wrap 23->00; the minutes carry is ignored.
    - Else: increment on the minutes carry, 23->00.
  - Adj_Min and Adj_Hour both high: both step on the same adj_stb, independently.
  - EN=0: seconds hold, normal carries are blocked; adjust still operates.
  - Tick and adj_stb in the same cycle: adjust path wins for the field being adjusted; seconds still count.
- 12-hour mapping, combinational from internal hour h:
  - h=0 -> 12;
  - h=1..12 -> h;
  - h=13..23 -> h-12;
  - all results in BCD.
  - PM = (h >= 12).
  - Changing Mode12 affects outputs only, never internal state.
- Alarm:
  - Arms when Alm_On=1, no adjust is active, and on a Tick the time becomes Alm_Hour:Alm_Min:00.
  - Alarm rises one cycle after the time registers show the match. It then stays high for ALARM_SEC ticks, counted by an 8-bit down-counter decremented on Tick, and falls when the count reaches 0.
  - Alarm clears on the next edge if Alm_On goes 0 or either adjust key rises.
  - An Alm_Hour/Alm_Min input that is out of range (hour > 23, minute > 59, or any digit > 9) never matches.
- Invalid BCD cannot occur internally. Every counter wraps explicitly, never via a binary overflow.

Optional Feature:
CLOCK_CHIME_EN:
- When defined: adds output Chime, 1 bit, reset 0. Chime asserts for exactly one tick period starting when minute:second becomes 00:00 via the normal carry, never via adjust. It is suppressed when EN=0.
- When undefined: no Chime port and no chime logic.

Test Plan:
All scenarios use CLK_HZ=8, TICK_HZ=1, ADJ_HZ=2.
1. Pulse nCR low mid-count at 12:34:56 -> all outputs return to their reset values asynchronously: 00:00:00, Tick=0, Alarm=0. Tick first appears 8 cycles after release.
2. Adjust to 23:59:50 with EN=1, run 10 ticks -> 23:59:59, then 00:00:00; PM goes 1->0 on the wrap; Tick pulses are exactly 1 cycle wide, 8 cycles apart.
3. Mode12=1 with internal hours 00, 11, 12, 13, 23 -> Hour reads 12, 11, 12, 01, 11 and PM reads 0, 0, 1, 1, 1.
4. Time 10:59:30, hold Adj_Min for 4 adjust strobes -> Minute goes 00, 01, 02, 03; Hour stays 10; Second keeps counting.
5. Alm_On=1, Alm=07:30, ALARM_SEC=3, run from 07:29:58 -> Alarm rises the cycle after 07:30:00 and stays high for 3 ticks. Repeat and drop Alm_On after 1 tick -> Alarm falls on the next edge.
6. EN=0 for 20 ticks at 05:05:05 -> time unchanged, Sec and Tick keep toggling. Adj_Hour during EN=0 still steps the hour to 06.

Source files
------------

// File: rtl/clock_core_param.sv
// clock_core_param
// Parametrised BCD timekeeping core for the seven-segment clock.
// Tick divider, auto-repeat adjust divider, 24-hour BCD time chain,
// combinational 12/24-hour output mapping and an HH:MM alarm with
// a bounded ring length.
//
// Optional feature macro: CLOCK_CHIME_EN (adds the Chime output).
//
// Ports:
//   CLK_50M   in   system clock, rising edge
//   nCR       in   asynchronous active-low reset
//   EN        in   1 = time runs, 0 = seconds frozen / carries blocked
//   Adj_Min   in   minute auto-repeat adjust (level)
//   Adj_Hour  in   hour auto-repeat adjust (level)
//   Mode12    in   1 = 12-hour output format
//   Alm_On    in   alarm enable
//   Alm_Hour  in   alarm hour, BCD
//   Alm_Min   in   alarm minute, BCD
//   Hour      out  BCD hour (00..23 or 01..12)
//   Minute    out  BCD minute
//   Second    out  BCD second
//   PM        out  internal hour >= 12
//   Sec       out  50% square wave at TICK_HZ
//   Tick      out  one-cycle strobe per tick
//   Alarm     out  alarm ringing
//   Chime     out  (CLOCK_CHIME_EN only) one tick period at each hour
module clock_core_param #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TICK_HZ   = 1,
    parameter int unsigned ADJ_HZ    = 4,
    parameter int unsigned ALARM_SEC = 30
) (
    input  logic       CLK_50M,
    input  logic       nCR,
    input  logic       EN,
    input  logic       Adj_Min,
    input  logic       Adj_Hour,
    input  logic       Mode12,
    input  logic       Alm_On,
    input  logic [7:0] Alm_Hour,
    input  logic [7:0] Alm_Min,
    output logic [7:0] Hour,
    output logic [7:0] Minute,
    output logic [7:0] Second,
    output logic       PM,
    output logic       Sec,
    output logic       Tick,
    output logic       Alarm
`ifdef CLOCK_CHIME_EN
    ,
    output logic       Chime
`endif
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned ADJ_DIV  = CLK_HZ / ADJ_HZ;
    localparam int unsigned TW       = $clog2(TICK_DIV);
    localparam int unsigned AW       = $clog2(ADJ_DIV);

    typedef enum logic {
        ALM_IDLE,
        ALM_RING
    } alm_state_t;

    // BCD increment with explicit wrap at maxv; never relies on binary overflow.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
        if (v == maxv)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [TW-1:0] tick_cnt;
    logic [AW-1:0] adj_cnt;
    logic          adj_any;
    logic          adj_stb;

    logic [7:0]    hour;
    logic [7:0]    minute;
    logic [7:0]    second;
    logic          sec_step;
    logic          sec_carry;
    logic          min_carry;

    alm_state_t    alm_state;
    alm_state_t    alm_state_nxt;
    logic [7:0]    ring_cnt;
    logic [7:0]    ring_cnt_nxt;
    logic          tick_seen;
    logic          adj_min_q;
    logic          adj_hour_q;
    logic          adj_rise;
    logic          alm_valid;
    logic          alm_match;

    // ---------------- dividers ----------------
    assign Tick    = (tick_cnt == TW'(TICK_DIV - 1));
    assign Sec     = (tick_cnt >= TW'(TICK_DIV / 2));
    assign adj_any = Adj_Min | Adj_Hour;
    assign adj_stb = adj_any && (adj_cnt == AW'(ADJ_DIV - 1));

    always_ff @(posedge CLK_50M or negedge nCR) begin
        if (!nCR) begin
            tick_cnt <= '0;
            adj_cnt  <= '0;
        end else begin
            tick_cnt <= Tick ? '0 : tick_cnt + TW'(1);
            // Held at zero while idle so the first step lands one full
            // adjust period after the key goes down.
            if (!adj_any || adj_stb)
                adj_cnt <= '0;
            else
                adj_cnt <= adj_cnt + AW'(1);
        end
    end

    // ---------------- time chain ----------------
    assign sec_step  = Tick && EN;
    assign sec_carry = sec_step && (second == 8'h59);
    assign min_carry = sec_carry && !Adj_Min && (minute == 8'h59);

    always_ff @(posedge CLK_50M or negedge nCR) begin
        if (!nCR) begin
            hour   <= '0;
            minute <= '0;
            second <= '0;
        end else begin
            if (sec_step)
                second <= bcd_inc(second, 8'h59);

            if (Adj_Min) begin
                if (adj_stb)
                    minute <= bcd_inc(minute, 8'h59);
            end else if (sec_carry) begin
                minute <= bcd_inc(minute, 8'h59);
            end

            if (Adj_Hour) begin
                if (adj_stb)
                    hour <= bcd_inc(hour, 8'h23);
            end else if (min_carry) begin
                hour <= bcd_inc(hour, 8'h23);
            end
        end
    end

    assign Minute = minute;
    assign Second = second;
    assign PM     = (hour >= 8'h12);

    // 12-hour view: 00->12, 13..19 -> 01..07, 20..23 -> 08..11.
    always_comb begin
        Hour = hour;
        if (Mode12) begin
            if (hour == 8'h00)
                Hour = 8'h12;
            else if (hour <= 8'h12)
                Hour = hour;
            else if (hour[7:4] == 4'd1)
                Hour = {4'd0, hour[3:0] - 4'd2};
            else if (hour[3:0] < 4'd2)
                Hour = {4'd0, hour[3:0] + 4'd8};
            else
                Hour = {4'd1, hour[3:0] - 4'd2};
        end
    end

    // ---------------- alarm ----------------
    assign alm_valid = (Alm_Hour[3:0] <= 4'd9) && (Alm_Min[3:0] <= 4'd9) &&
                       (Alm_Hour <= 8'h23) && (Alm_Min <= 8'h59);
    // tick_seen marks the cycle right after a counted tick, i.e. the first
    // cycle in which the registers show the newly ticked time.
    assign alm_match = tick_seen && alm_valid && Alm_On && !adj_any &&
                       (hour == Alm_Hour) && (minute == Alm_Min) &&
                       (second == 8'h00);
    assign adj_rise  = (Adj_Min && !adj_min_q) || (Adj_Hour && !adj_hour_q);

    always_comb begin
        alm_state_nxt = alm_state;
        ring_cnt_nxt  = ring_cnt;
        case (alm_state)
            ALM_IDLE: begin
                if (alm_match) begin
                    alm_state_nxt = ALM_RING;
                    ring_cnt_nxt  = 8'(ALARM_SEC);
                end
            end
            ALM_RING: begin
                if (!Alm_On || adj_rise) begin
                    alm_state_nxt = ALM_IDLE;
                    ring_cnt_nxt  = '0;
                end else if (Tick) begin
                    if (ring_cnt <= 8'd1) begin
                        alm_state_nxt = ALM_IDLE;
                        ring_cnt_nxt  = '0;
                    end else begin
                        ring_cnt_nxt  = ring_cnt - 8'd1;
                    end
                end
            end
            default: begin
                alm_state_nxt = ALM_IDLE;
                ring_cnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_50M or negedge nCR) begin
        if (!nCR) begin
            alm_state  <= ALM_IDLE;
            ring_cnt   <= '0;
            tick_seen  <= 1'b0;
            adj_min_q  <= 1'b0;
            adj_hour_q <= 1'b0;
        end else begin
            alm_state  <= alm_state_nxt;
            ring_cnt   <= ring_cnt_nxt;
            tick_seen  <= sec_step && !adj_any;
            adj_min_q  <= Adj_Min;
            adj_hour_q <= Adj_Hour;
        end
    end

    assign Alarm = (alm_state == ALM_RING);

`ifdef CLOCK_CHIME_EN
    // Only the normal carry into 00:00 sets the chime; it lasts until the
    // following tick, giving exactly one tick period.
    always_ff @(posedge CLK_50M or negedge nCR) begin
        if (!nCR)
            Chime <= 1'b0;
        else if (Tick)
            Chime <= min_carry;
    end
`endif

endmodule
